seg7_scan_driver: RTL and testbench



---
 rtl/seg7_scan_driver_if.sv | 22 ++
 rtl/seg7_scan_driver.sv | 110 +++++++++++
 tb/tb_seg7_scan_driver.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/seg7_scan_driver_if.sv
// rtl/seg7_scan_driver_if.sv - display data in / segment+digit drive out bundle for seg7_scan_driver
interface seg7_scan_driver_if #(
    parameter int NUM_DIG = 6
);
    logic [4*NUM_DIG-1:0] data;
    logic [NUM_DIG-1:0]   dp;
    logic [NUM_DIG-1:0]   blank;
    logic [3:0]           bright;
    logic [7:0]           seg;
    logic [NUM_DIG-1:0]   dig;
    logic                 frame_start;

    modport master (
        output data, dp, blank, bright,
        input  seg, dig, frame_start
    );

    modport slave (
        input  data, dp, blank, bright,
        output seg, dig, frame_start
    );
endinterface

// File: rtl/seg7_scan_driver.sv
// rtl/seg7_scan_driver.sv - multiplexed 7-segment scan driver with frame snapshots and duty control
// Optional leading-zero blanking: define SEG7_LZ_BLANK_EN.
module seg7_scan_driver #(
    parameter int NUM_DIG = 6,
    parameter int CLK_DIV = 25000
) (
    input  logic               clkin,
    input  logic               rst_n,
    seg7_scan_driver_if.slave  disp
);
    localparam int PW = $clog2(CLK_DIV + 1);
    localparam int SW = $clog2(NUM_DIG);
    localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_DIV - 1);
    localparam logic [SW-1:0] SLOT_MAX  = SW'(NUM_DIG - 1);

    logic [PW-1:0]        presc;
    logic [PW-1:0]        on_thr;
    logic [SW-1:0]        slot;
    logic                 started;
    logic [4*NUM_DIG-1:0] data_snap;
    logic [NUM_DIG-1:0]   dp_snap;
    logic [NUM_DIG-1:0]   blank_snap;
    logic [NUM_DIG-1:0]   blank_eff;
    logic                 tick;
    logic                 snap_en;
    logic                 lit;
    logic [3:0]           code;
    logic [6:0]           glyph;
    logic [31:0]          thr_wide;

    assign tick     = (presc == PRESC_MAX);
    // first cycle after reset release also snapshots, so slot 0 never shows stale zeros
    assign snap_en  = !started || (tick && (slot == SLOT_MAX));
    assign thr_wide = ((32'(disp.bright) + 32'd1) * 32'(CLK_DIV)) >> 4;
    assign code     = data_snap[4*slot +: 4];

`ifdef SEG7_LZ_BLANK_EN
    logic lead;
    always_comb begin
        lead      = 1'b1;
        blank_eff = blank_snap;
        for (int i = NUM_DIG - 1; i > 0; i--) begin
            if (lead && (data_snap[4*i +: 4] == 4'd0) && !dp_snap[i]) begin
                blank_eff[i] = 1'b1;
            end else begin
                lead = 1'b0;
            end
        end
    end
`else
    assign blank_eff = blank_snap;
`endif

    // the tick cycle is always dark: this is the inter-digit anti-ghosting break
    assign lit = !tick && (presc < on_thr) && !blank_eff[slot];

    always_comb begin
        glyph = 7'b0000000;
        case (code)
            4'd0:    glyph = 7'b1111110;
            4'd1:    glyph = 7'b0110000;
            4'd2:    glyph = 7'b1101101;
            4'd3:    glyph = 7'b1111001;
            4'd4:    glyph = 7'b0110011;
            4'd5:    glyph = 7'b1011011;
            4'd6:    glyph = 7'b1011111;
            4'd7:    glyph = 7'b1110000;
            4'd8:    glyph = 7'b1111111;
            4'd9:    glyph = 7'b1111011;
            4'd10:   glyph = 7'b0000001;
            4'd11:   glyph = 7'b1000000;
            4'd12:   glyph = 7'b0001000;
            4'd13:   glyph = 7'b0110111;
            4'd14:   glyph = 7'b0001110;
            default: glyph = 7'b0000000;
        endcase
    end

    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            presc            <= '0;
            slot             <= '0;
            started          <= 1'b0;
            on_thr           <= '0;
            data_snap        <= '0;
            dp_snap          <= '0;
            blank_snap       <= '0;
            disp.dig         <= '1;
            disp.seg         <= 8'h00;
            disp.frame_start <= 1'b0;
        end else begin
            started <= 1'b1;
            if (snap_en) begin
                data_snap  <= disp.data;
                dp_snap    <= disp.dp;
                blank_snap <= disp.blank;
                on_thr     <= PW'(thr_wide);
            end
            if (started) begin
                presc <= tick ? '0 : presc + 1'b1;
                if (tick) begin
                    slot <= (slot == SLOT_MAX) ? '0 : slot + 1'b1;
                end
                disp.dig         <= lit ? ~(NUM_DIG'(1) << slot) : '1;
                disp.seg         <= lit ? {glyph, dp_snap[slot]} : 8'h00;
                disp.frame_start <= (presc == '0) && (slot == '0);
            end
        end
    end
endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb/tb_seg7_scan_driver.sv - self-checking bench for seg7_scan_driver (NUM_DIG=4, CLK_DIV=16)
module tb_seg7_scan_driver;
    localparam int N = 4;
    localparam int D = 16;

    logic clkin = 1'b0;
    logic rst_n = 1'b0;

    seg7_scan_driver_if #(.NUM_DIG(N)) disp ();
    seg7_scan_driver #(.NUM_DIG(N), .CLK_DIV(D)) dut (
        .clkin (clkin),
        .rst_n (rst_n),
        .disp  (disp)
    );

    always #5 clkin = ~clkin;

    int checks = 0;
    int errors = 0;
    int k = 0;

    logic [6:0] glyph_tab [16] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                                   7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
                                   7'b1111111, 7'b1111011, 7'b0000001, 7'b1000000,
                                   7'b0001000, 7'b0110111, 7'b0001110, 7'b0000000};

    logic [15:0] h1_data, h2_data, s_data;
    logic [3:0]  h1_dp, h2_dp, s_dp;
    logic [3:0]  h1_blank, h2_blank, s_blank;
    logic [3:0]  h1_bright, h2_bright, s_bright;
    int          m_n, m_pos, m_slot, m_thr, m_top;
    logic [3:0]  m_dark;
    logic        m_lit;
    logic [3:0]  e_dig;
    logic [7:0]  e_seg;
    logic        e_fs;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // output cycle index since scan start: first frame_start output is n=0
    always @(posedge clkin) begin
        if (rst_n) k = k + 1;
        else       k = 0;
    end

    always @(negedge clkin) begin
        m_n = k - 2;
        if (!rst_n || m_n < 0) begin
            e_dig = 4'hF;
            e_seg = 8'h00;
            e_fs  = 1'b0;
        end else begin
            m_pos  = m_n % D;
            m_slot = (m_n / D) % N;
            if (m_pos == 0 && m_slot == 0) begin
                s_data   = h2_data;
                s_dp     = h2_dp;
                s_blank  = h2_blank;
                s_bright = h2_bright;
            end
            m_dark = s_blank;
`ifdef SEG7_LZ_BLANK_EN
            m_top = 0;
            for (int i = 0; i < N; i++)
                if (s_data[4*i +: 4] != 4'd0 || s_dp[i]) m_top = i;
            for (int i = 0; i < N; i++)
                if (i > m_top) m_dark[i] = 1'b1;
`endif
            m_thr = ((int'(s_bright) + 1) * D) / 16;
            m_lit = (m_pos < m_thr) && (m_pos != D - 1) && !m_dark[m_slot];
            e_dig = m_lit ? ~(4'b0001 << m_slot) : 4'hF;
            e_seg = m_lit ? {glyph_tab[s_data[4*m_slot +: 4]], s_dp[m_slot]} : 8'h00;
            e_fs  = (m_pos == 0 && m_slot == 0);
        end
        check("model_dig", 32'(disp.dig), 32'(e_dig));
        check("model_seg", 32'(disp.seg), 32'(e_seg));
        check("model_frame_start", 32'(disp.frame_start), 32'(e_fs));
        h2_data = h1_data;  h1_data = disp.data;
        h2_dp = h1_dp;      h1_dp = disp.dp;
        h2_blank = h1_blank; h1_blank = disp.blank;
        h2_bright = h1_bright; h1_bright = disp.bright;
    end

    task automatic to_n(input int m);
        bit hit = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(posedge clkin);
            #1;
            if (k - 2 == m) begin
                hit = 1'b1;
                break;
            end
        end
        checks++;
        if (!hit) begin
            errors++;
            $display("FAIL timeout waiting for n=%0d: got k=%0d expected k=%0d", m, k, m + 2);
        end
    endtask

    task automatic lit_at(input int m, input string name, input logic [3:0] d, input logic [7:0] s);
        to_n(m);
        @(negedge clkin);
        check({name, "_dig"}, 32'(disp.dig), 32'(d));
        check({name, "_seg"}, 32'(disp.seg), 32'(s));
    endtask

    initial begin
        disp.data   = 16'h4321;
        disp.dp     = 4'b0000;
        disp.blank  = 4'b0000;
        disp.bright = 4'd15;
        repeat (3) @(posedge clkin);
        #1;
        check("reset_dig", 32'(disp.dig), 32'hF);
        check("reset_seg", 32'(disp.seg), 32'h00);
        check("reset_fs", 32'(disp.frame_start), 32'h0);
        rst_n = 1'b1;

        lit_at(0, "t1_slot0", 4'b1110, 8'h60);
        check("t1_fs_n0", 32'(disp.frame_start), 32'h1);
        lit_at(1, "t1_slot0b", 4'b1110, 8'h60);
        check("t1_fs_n1", 32'(disp.frame_start), 32'h0);
        lit_at(15, "t1_break", 4'b1111, 8'h00);
        lit_at(16, "t1_slot1", 4'b1101, 8'hDA);

        to_n(20);
        disp.dp    = 4'b0100;
        disp.blank = 4'b1000;
        lit_at(48, "t2_old_frame", 4'b0111, 8'h66);
        lit_at(96, "t2_dp", 4'b1011, 8'hF3);
        lit_at(112, "t2_blank", 4'b1111, 8'h00);

        to_n(120);
        disp.dp     = 4'b0000;
        disp.blank  = 4'b0000;
        disp.bright = 4'd3;
        lit_at(131, "t3_on", 4'b1110, 8'h60);
        lit_at(132, "t3_off", 4'b1111, 8'h00);

        to_n(148);
        disp.data = 16'h9999;
        lit_at(176, "t4_no_tear", 4'b0111, 8'h66);
        lit_at(192, "t4_next_frame", 4'b1110, 8'hF6);

        lit_at(226, "t5_before_rst", 4'b1011, 8'hF6);
        #2;
        rst_n = 1'b0;
        #1;
        check("t5_async_dig", 32'(disp.dig), 32'hF);
        check("t5_async_seg", 32'(disp.seg), 32'h00);
        check("t5_async_fs", 32'(disp.frame_start), 32'h0);
        repeat (2) @(posedge clkin);
        #1;
        rst_n = 1'b1;
        lit_at(0, "t5_restart", 4'b1110, 8'hF6);
        check("t5_restart_fs", 32'(disp.frame_start), 32'h1);

        to_n(10);
        disp.data   = 16'h0050;
        disp.bright = 4'd15;
        lit_at(64, "t6_d0", 4'b1110, 8'hFC);
        lit_at(80, "t6_d1", 4'b1101, 8'hB6);
`ifdef SEG7_LZ_BLANK_EN
        lit_at(96, "t6_lz_d2", 4'b1111, 8'h00);
        lit_at(112, "t6_lz_d3", 4'b1111, 8'h00);
`else
        lit_at(96, "t6_d2", 4'b1011, 8'hFC);
        lit_at(112, "t6_d3", 4'b0111, 8'hFC);
`endif
        disp.data = 16'h0000;
        lit_at(128, "t6_zero_d0", 4'b1110, 8'hFC);
`ifdef SEG7_LZ_BLANK_EN
        lit_at(144, "t6_lz_zero_d1", 4'b1111, 8'h00);
`else
        lit_at(144, "t6_zero_d1", 4'b1101, 8'hFC);
`endif
        to_n(200);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
